// File: rtl/fsk_tx_ctrl.sv
// ---------------------------------------------------------------------------
// fsk_tx_ctrl : UART-style bit framer driving mark/space NCO tuning words.
// Optional even parity bit when FSK_TX_PARITY_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fsk_tx_ctrl #(
  parameter int               BAUD_DIV  = 5208,
  parameter int               FTW_W     = 32,
  parameter logic [FTW_W-1:0] FTW_MARK  = FTW_W'(32'd21474836),
  parameter logic [FTW_W-1:0] FTW_SPACE = FTW_W'(32'd42949673)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [FTW_W-1:0] ftw_out,
  output logic             bit_out,
  output logic             sym_strobe,
  output logic             busy,
  output logic             frame_done
);

  localparam int               CNT_W      = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BAUD_DIV - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef FSK_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       idx_q,   idx_d;
  logic [7:0]       shift_q, shift_d;
`ifdef FSK_TX_PARITY_EN
  logic             par_q,   par_d;
`endif
  logic             bit_end;
  logic             accept;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
`ifdef FSK_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
`ifdef FSK_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef FSK_TX_PARITY_EN
    par_d   = par_q;
`endif
    bit_end = (cnt_q == '0);
    accept  = din_valid & din_ready;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? CNT_RELOAD : cnt_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          cnt_d   = CNT_RELOAD;
          idx_d   = '0;
          shift_d = din;
`ifdef FSK_TX_PARITY_EN
          par_d   = ^din;
`endif
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) begin
`ifdef FSK_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef FSK_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Accepting on the final stop cycle chains frames with no mark gap.
        if (bit_end) begin
          if (accept) begin
            state_d = S_START;
            cnt_d   = CNT_RELOAD;
            idx_d   = '0;
            shift_d = din;
`ifdef FSK_TX_PARITY_EN
            par_d   = ^din;
`endif
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    din_ready  = ~sys_rst & ((state_q == S_IDLE) | ((state_q == S_STOP) & (cnt_q == '0)));
    busy       = (state_q != S_IDLE);
    sym_strobe = (state_q != S_IDLE) & (cnt_q == CNT_RELOAD);
    frame_done = (state_q == S_STOP) & (cnt_q == '0);
    case (state_q)
      S_START:  bit_out = 1'b0;
      S_DATA:   bit_out = shift_q[0];
`ifdef FSK_TX_PARITY_EN
      S_PARITY: bit_out = par_q;
`endif
      default:  bit_out = 1'b1;
    endcase
    ftw_out = bit_out ? FTW_MARK : FTW_SPACE;
  end

endmodule

`default_nettype wire

// File: tb/tb_fsk_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fsk_tx_ctrl : directed bench for fsk_tx_ctrl with BAUD_DIV = 4.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fsk_tx_ctrl;

  localparam int          BD    = 4;
  localparam logic [31:0] MARK  = 32'd21474836;
  localparam logic [31:0] SPACE = 32'd42949673;
`ifdef FSK_TX_PARITY_EN
  localparam int          NB    = 11;
`else
  localparam int          NB    = 10;
`endif

  logic        sys_clk   = 1'b0;
  logic        sys_rst   = 1'b1;
  logic [7:0]  din       = 8'h00;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [31:0] ftw_out;
  logic        bit_out;
  logic        sym_strobe;
  logic        busy;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  fsk_tx_ctrl #(.BAUD_DIV(BD)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .ftw_out    (ftw_out),
    .bit_out    (bit_out),
    .sym_strobe (sym_strobe),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Frame bit p of byte b: start, LSB-first data, optional even parity, stop.
  function automatic logic exp_bit(input logic [7:0] b, input int p);
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
`ifdef FSK_TX_PARITY_EN
    if (p == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (din_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("ready_wait", {31'd0, din_ready}, 32'd1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready();
    din       = b;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_bit"},   {31'd0, bit_out},    32'd1);
    chk({tag, "_ftw"},   ftw_out,             MARK);
    chk({tag, "_busy"},  {31'd0, busy},       32'd0);
    chk({tag, "_rdy"},   {31'd0, din_ready},  32'd0);
    chk({tag, "_strb"},  {31'd0, sym_strobe}, 32'd0);
    chk({tag, "_done"},  {31'd0, frame_done}, 32'd0);
  endtask

  // Starts on the first START cycle; ends on the cycle after the stop bit.
  task automatic check_frame(input logic [7:0] b, input bit toggle);
    logic eb;
    bit   last;
    for (int k = 0; k < NB*BD; k++) begin
      last = (k == NB*BD-1);
      eb   = exp_bit(b, k / BD);
      if (toggle) begin
        din_valid = k[0] && !last;
        din       = 8'hC3 ^ 8'(k);
      end
      chk("bit_out",    {31'd0, bit_out},    {31'd0, eb});
      chk("ftw_out",    ftw_out,             eb ? MARK : SPACE);
      chk("sym_strobe", {31'd0, sym_strobe}, {31'd0, (k % BD) == 0});
      chk("frame_done", {31'd0, frame_done}, {31'd0, last});
      chk("busy",       {31'd0, busy},       32'd1);
      chk("din_ready",  {31'd0, din_ready},  {31'd0, last});
      tick();
    end
  endtask

  initial begin
    // Reset held
    repeat (3) tick();
    reset_vals("rst_hold");
    sys_rst = 1'b0;
    #1;
    chk("rel_rdy",  {31'd0, din_ready}, 32'd1);
    chk("rel_bit",  {31'd0, bit_out},   32'd1);
    chk("rel_ftw",  ftw_out,            MARK);
    chk("rel_busy", {31'd0, busy},      32'd0);

    // Single frame 0xA5
    send(8'hA5);
    check_frame(8'hA5, 1'b0);
    chk("a5_idle_busy", {31'd0, busy},       32'd0);
    chk("a5_idle_done", {31'd0, frame_done}, 32'd0);
    chk("a5_idle_rdy",  {31'd0, din_ready},  32'd1);

    // Back-to-back 0x00 then 0xFF
    wait_ready();
    din       = 8'h00;
    din_valid = 1'b1;
    tick();
    din       = 8'hFF;
    check_frame(8'h00, 1'b0);
    din_valid = 1'b0;
    check_frame(8'hFF, 1'b0);
    chk("b2b_busy", {31'd0, busy}, 32'd0);

    // Reset at cycle 15 of a frame
    send(8'h81);
    repeat (14) tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    sys_rst = 1'b1;
    #1;
    reset_vals("async_rst");
    tick();
    chk("rst_done1", {31'd0, frame_done}, 32'd0);
    tick();
    chk("rst_done2", {31'd0, frame_done}, 32'd0);
    sys_rst = 1'b0;
    #1;
    chk("rst_rel_rdy", {31'd0, din_ready}, 32'd1);
    send(8'h3C);
    check_frame(8'h3C, 1'b0);

    // Parity patterns (odd and even popcount)
    send(8'h07);
    check_frame(8'h07, 1'b0);
    send(8'h03);
    check_frame(8'h03, 1'b0);

    // din_valid toggling mid-frame must not cause extra accepts
    send(8'h96);
    check_frame(8'h96, 1'b1);
    din_valid = 1'b0;
    chk("tog_busy",  {31'd0, busy},      32'd0);
    chk("tog_rdy",   {31'd0, din_ready}, 32'd1);
    tick();
    chk("tog_busy2", {31'd0, busy},      32'd0);
    chk("tog_bit",   {31'd0, bit_out},   32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
